// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: access-size encodings, FSM
// states and the request legality check.
package mem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A request is illegal if its size is reserved, it is misaligned for its
  // size, or it addresses beyond the 2**addr_w-word array.
  function automatic logic req_illegal(input logic [31:0] addr,
                                       input logic [1:0]  size,
                                       input int unsigned addr_w);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if ((addr >> (addr_w + 2)) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: merges right-aligned write data into the
// old word and extracts the addressed lanes of a read, zero-extended.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] merged_word,
  output logic [31:0] read_word
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;

  // NOTE: every output gets a default before the case so no path can leave a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_shifted = old_word >> {lane, 3'b000};
    half_shifted = old_word >> {lane[1], 4'b0000};
    merged_word  = old_word;
    read_word    = '0;
    case (size)
      SZ_BYTE: begin
        merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
        read_word = {24'd0, byte_shifted[7:0]};
      end
      SZ_HALF: begin
        merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        read_word = {16'd0, half_shifted[15:0]};
      end
      SZ_WORD: begin
        merged_word = wdata;
        read_word   = old_word;
      end
      default: begin
        merged_word = old_word;
        read_word   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: word-organised RAM behind a
// req/ack handshake with configurable wait states and sub-word access.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W+1:0] r_addr;
  logic              r_we;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [31:0]       read_word;

  assign word_idx = r_addr[ADDR_W+1:2];
  assign old_word = mem[word_idx];

  mem_lane_align u_align (
    .old_word    (old_word),
    .wdata       (r_wdata),
    .lane        (r_addr[1:0]),
    .size        (r_size),
    .merged_word (merged_word),
    .read_word   (read_word)
  );

  // NOTE: the RAM has no reset branch; its contents survive reset and a
  // reset-free array maps onto plain memory macros.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && r_we && !r_err) mem[word_idx] <= merged_word;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_wdata <= '0;
      r_err   <= 1'b0;
      rdata   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            r_addr  <= addr[ADDR_W+1:0];
            r_we    <= we;
            r_size  <= size;
            r_wdata <= wdata;
            r_err   <= req_illegal(addr, size, ADDR_W);
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ST_ACCESS: begin
          // Response is registered here so it is visible throughout RESP.
          ack   <= 1'b1;
          err   <= r_err;
          if (r_err)     rdata <= '0;
          else if (!r_we) rdata <= read_word;
          state <= ST_RESP;
        end
        ST_RESP: begin
          // req is deliberately not sampled here; a held req is taken in IDLE.
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
